// File: rtl/_skid_reg_pkg.sv
// Shared constants and types for the pipeline register slice.
package _skid_reg_pkg;

    localparam int WORD_LENGTH = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/_skid_reg_dff.sv
// Word register with synchronous clear and load enable.
import _skid_reg_pkg::*;

module _skid_reg_dff #(
    parameter int n = WORD_LENGTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [n-1:0] d,
    output logic [n-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/_skid_reg.sv
// Two-entry valid/ready skid buffer; in_ready is registered so no
// combinational ready path crosses the slice.
import _skid_reg_pkg::*;

module _skid_reg #(
    parameter int n = WORD_LENGTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_data,
    output logic [1:0]   count
);

    skid_state_t  state_q;
    skid_state_t  state_d;
    logic         in_ready_q;
    logic         in_fire;
    logic         out_fire;
    logic         load_main;
    logic         load_skid;
    logic         main_from_skid;
    logic [n-1:0] main_d;
    logic [n-1:0] skid_q;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign count     = state_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;
    assign main_d    = main_from_skid ? skid_q : in_data;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = TWO;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops everything, including a word accepted this cycle.
        if (flush) begin
            state_d   = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    _skid_reg_dff #(.n(n)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (load_main),
        .d   (main_d),
        .q   (out_data)
    );

    _skid_reg_dff #(.n(n)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (load_skid),
        .d   (in_data),
        .q   (skid_q)
    );

endmodule
